melody_sequencer: RTL and testbench

- Programmable note sequencer that sits directly upstream of the PWM tone synth.
- Holds a 64-entry melody RAM loaded by the host, and steps through it at a fixed tempo counted in synth sample ticks.
- Presents each note code to the synth over a valid/ready handshake, plus a gate level for articulation.
- Lets the team change tunes without respinning a hard-coded melody table.

---
 rtl/melody_sequencer_if.sv | 27 ++
 rtl/melody_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_melody_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// melody_sequencer_if : note handshake between the melody sequencer and synth
// Revision: 1.0
// ============================================================================
interface melody_sequencer_if;
    logic [3:0] note;
    logic       note_valid;
    logic       note_ready;
    logic       gate;

    modport master (
        output note,
        output note_valid,
        output gate,
        input  note_ready
    );

    modport slave (
        input  note,
        input  note_valid,
        input  gate,
        output note_ready
    );
endinterface
`default_nettype wire

// File: rtl/melody_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// melody_sequencer : host-loaded melody RAM stepped at a tick-counted tempo
// Optional articulation gap: define MELODY_SEQ_ARTIC_GAP_EN
// Revision: 1.0
// ============================================================================
module melody_sequencer #(
    parameter  int unsigned TICKS_PER_EIGHTH = 50000,
    parameter  int unsigned GAP_TICKS        = 2500,
    parameter  int unsigned DEPTH            = 64,
    localparam int unsigned ADDR_W           = $clog2(DEPTH),
    localparam int unsigned DUR_W            = $clog2(TICKS_PER_EIGHTH * 8 + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [7:0]            wr_data,
    melody_sequencer_if.master    synth,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     idx
);

    localparam logic [3:0] c_NOTE_END  = 4'hE;
    localparam logic [3:0] c_NOTE_REST = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OFFER  = 3'd3,
        S_PLAY   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [3:0]          note_q, note_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [DUR_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                end_of_melody;

    logic [7:0]          mem [DEPTH];
    logic [7:0]          rd_data_q;

    logic [3:0]          w_rd_note;
    logic [DUR_W-1:0]    w_rd_dur;
    logic [DUR_W-1:0]    w_cnt_inc;
    logic                w_last_entry;
    logic                w_gate_allow;
    logic                w_rsvd_unused;

    // Read port runs every cycle; DECODE consumes the word fetched in FETCH.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[idx_q];
    end

    assign w_rd_note     = rd_data_q[7:4];
    assign w_rd_dur      = DUR_W'(TICKS_PER_EIGHTH) << rd_data_q[1:0];
    assign w_rsvd_unused = ^rd_data_q[3:2];
    assign w_cnt_inc     = cnt_q + DUR_W'(1);
    assign w_last_entry  = (idx_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            note_q  <= c_NOTE_REST;
            dur_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        note_d        = note_q;
        dur_d         = dur_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        end_of_melody = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (w_rd_note == c_NOTE_END) begin
                    end_of_melody = 1'b1;
                end else begin
                    note_d  = w_rd_note;
                    dur_d   = w_rd_dur;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (synth.note_ready) begin
                    cnt_d   = '0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick_in) begin
                    cnt_d = w_cnt_inc;
                    if (w_cnt_inc == dur_q) begin
                        // Running off the last entry is treated like an END marker.
                        if (w_last_entry) begin
                            end_of_melody = 1'b1;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (end_of_melody) begin
            idx_d = '0;
            if (loop_en) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
                note_d  = c_NOTE_REST;
                done_d  = 1'b1;
            end
        end

        if (stop) begin
            state_d = S_IDLE;
            idx_d   = '0;
            note_d  = c_NOTE_REST;
            done_d  = 1'b0;
        end
    end

`ifdef MELODY_SEQ_ARTIC_GAP_EN
    // Gate drops once the remaining ticks reach the gap length.
    assign w_gate_allow = (32'(dur_q) > (32'(cnt_q) + GAP_TICKS));
`else
    logic w_gap_unused;
    assign w_gap_unused = (GAP_TICKS != 0);
    assign w_gate_allow = 1'b1;
`endif

    assign synth.note       = note_q;
    assign synth.note_valid = (state_q == S_OFFER);
    assign synth.gate       = (state_q == S_PLAY) && (note_q != c_NOTE_REST) && w_gate_allow;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign idx              = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_melody_sequencer : directed self-checking bench for melody_sequencer
// Revision: 1.0
// ============================================================================
module tb_melody_sequencer;

    localparam int unsigned TPE   = 4;
    localparam int unsigned GAP   = 1;
    localparam int unsigned DEPTH = 64;
`ifdef MELODY_SEQ_ARTIC_GAP_EN
    localparam int EXP_GATE = 3;
    localparam int EXP_GAP  = 1;
`else
    localparam int EXP_GATE = 4;
    localparam int EXP_GAP  = 0;
`endif

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       tick_in = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       loop_en = 1'b0;
    logic       wr_en   = 1'b0;
    logic [5:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       busy;
    logic       done;
    logic [5:0] idx;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_ph  = 0;

    melody_sequencer_if sif ();

    melody_sequencer #(
        .TICKS_PER_EIGHTH (TPE),
        .GAP_TICKS        (GAP),
        .DEPTH            (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .synth   (sif),
        .busy    (busy),
        .done    (done),
        .idx     (idx)
    );

    always #5 clk = ~clk;

    // Sample-rate strobe: one cycle high out of every three.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_ph = (tick_ph + 1) % 3;
            tick_in = (tick_ph == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1);
    end

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load_basic();
        wr(6'd0, 8'h20);
        wr(6'd1, 8'hF1);
        wr(6'd2, 8'hE0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic do_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (sif.note !== 4'hF) begin n_fail++; $display("FAIL reset_note: got %h expected f", sif.note); end
        n_checks++; if (sif.note_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sif.note_valid); end
        n_checks++; if (sif.gate !== 1'b0) begin n_fail++; $display("FAIL reset_gate: got %b expected 0", sif.gate); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", idx); end
    endtask

    task automatic test_basic();
        logic v [3];
        int   gate_t = 0;
        int   gap_t  = 0;
        int   rest_t = 0;
        int   done_c = 0;
        bit   seen_gate = 1'b0;
        bit   fin = 1'b0;
        load_basic();
        loop_en = 1'b0;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v[k] = sif.note_valid;
        end
        n_checks++; if (v[0] !== 1'b0) begin n_fail++; $display("FAIL basic_valid_n1: got %b expected 0", v[0]); end
        n_checks++; if (v[1] !== 1'b0) begin n_fail++; $display("FAIL basic_valid_n2: got %b expected 0", v[1]); end
        n_checks++; if (v[2] !== 1'b1) begin n_fail++; $display("FAIL basic_valid_n3: got %b expected 1", v[2]); end
        n_checks++; if (sif.note !== 4'h2) begin n_fail++; $display("FAIL basic_note: got %h expected 2", sif.note); end
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            if (sif.gate) begin
                seen_gate = 1'b1;
                if (tick_in) gate_t++;
            end else if (seen_gate && busy && !sif.note_valid && tick_in) begin
                if (sif.note == 4'hF) rest_t++;
                else if (sif.note == 4'h2) gap_t++;
            end
            if (done) done_c++;
            if (seen_gate && !busy) fin = 1'b1;
        end
        n_checks++; if (!fin) begin n_fail++; $display("FAIL basic_timeout: got busy=%b expected idle within 300 cycles", busy); end
        n_checks++; if (gate_t != EXP_GATE) begin n_fail++; $display("FAIL basic_gate_ticks: got %0d expected %0d", gate_t, EXP_GATE); end
        n_checks++; if (gap_t != EXP_GAP) begin n_fail++; $display("FAIL basic_gap_ticks: got %0d expected %0d", gap_t, EXP_GAP); end
        n_checks++; if (rest_t != 8) begin n_fail++; $display("FAIL basic_rest_ticks: got %0d expected 8", rest_t); end
        n_checks++; if (done_c != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_c); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int stable = 0;
        int gate_t = 0;
        bit found  = 1'b0;
        bit fin    = 1'b0;
        sif.note_ready = 1'b0;
        pulse_start();
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (sif.note_valid) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL bp_offer: got no note_valid expected within 10 cycles"); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sif.note_valid && sif.note == 4'h2 && !sif.gate) stable++;
        end
        n_checks++; if (stable != 20) begin n_fail++; $display("FAIL bp_stable: got %0d expected 20", stable); end
        @(posedge clk); #1 sif.note_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (sif.note_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b expected 0", sif.note_valid); end
        n_checks++; if (sif.gate !== 1'b1) begin n_fail++; $display("FAIL bp_gate_rise: got %b expected 1", sif.gate); end
        if (sif.gate && tick_in) gate_t++;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(negedge clk);
            if (sif.gate && tick_in) gate_t++;
            if (!busy) fin = 1'b1;
        end
        n_checks++; if (!fin) begin n_fail++; $display("FAIL bp_timeout: got busy=%b expected idle within 300 cycles", busy); end
        n_checks++; if (gate_t != EXP_GATE) begin n_fail++; $display("FAIL bp_gate_ticks: got %0d expected %0d", gate_t, EXP_GATE); end
    endtask

    task automatic test_loop();
        logic [3:0] on [3];
        logic [5:0] oi [3];
        int   n_off  = 0;
        int   done_c = 0;
        logic prev_v = 1'b0;
        loop_en = 1'b1;
        pulse_start();
        for (int c = 0; c < 300 && n_off < 3; c++) begin
            @(negedge clk);
            if (sif.note_valid && !prev_v) begin
                on[n_off] = sif.note;
                oi[n_off] = idx;
                n_off++;
            end
            prev_v = sif.note_valid;
            if (done) done_c++;
        end
        n_checks++; if (n_off != 3) begin n_fail++; $display("FAIL loop_offers: got %0d expected 3", n_off); end
        if (n_off == 3) begin
            n_checks++; if (on[1] !== 4'hF || oi[1] !== 6'd1) begin n_fail++; $display("FAIL loop_rest: got note %h idx %0d expected f idx 1", on[1], oi[1]); end
            n_checks++; if (on[2] !== 4'h2) begin n_fail++; $display("FAIL loop_reoffer_note: got %h expected 2", on[2]); end
            n_checks++; if (oi[2] !== 6'd0) begin n_fail++; $display("FAIL loop_reoffer_idx: got %0d expected 0", oi[2]); end
        end
        n_checks++; if (done_c != 0) begin n_fail++; $display("FAIL loop_no_done: got %0d expected 0", done_c); end
        loop_en = 1'b0;
        do_stop();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_stop_busy: got %b expected 0", busy); end
    endtask

    task automatic test_stop();
        bit found = 1'b0;
        int bad   = 0;
        pulse_start();
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (idx == 6'd1 && busy && !sif.note_valid && sif.note == 4'hF) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL stop_reach_rest: got no rest play expected within 200 cycles"); end
        repeat (6) @(negedge clk);
        do_stop();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b expected 0", busy); end
        n_checks++; if (sif.gate !== 1'b0) begin n_fail++; $display("FAIL stop_gate: got %b expected 0", sif.gate); end
        n_checks++; if (idx !== 6'd0) begin n_fail++; $display("FAIL stop_idx: got %0d expected 0", idx); end
        n_checks++; if (sif.note !== 4'hF) begin n_fail++; $display("FAIL stop_note: got %h expected f", sif.note); end
        n_checks++; if (sif.note_valid !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL stop_valid_done: got %b/%b expected 0/0", sif.note_valid, done); end
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || sif.note_valid || done) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stop_start_same_cycle: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_fill_wrap();
        int   offers   = 0;
        int   bad_note = 0;
        int   bad5     = 0;
        int   g5       = 0;
        int   done_c   = 0;
        bit   rewrote  = 1'b0;
        bit   fin      = 1'b0;
        logic prev_v   = 1'b0;
        for (int i = 0; i < 64; i++) wr(6'(i), 8'h40);
        loop_en = 1'b0;
        pulse_start();
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (sif.note_valid && !prev_v) begin
                offers++;
                if (sif.note !== 4'h4) bad_note++;
            end
            if (busy && idx == 6'd5 && sif.note !== 4'h4) bad5++;
            if (sif.gate && tick_in && idx == 6'd5) g5++;
            if (!rewrote && busy && !sif.note_valid && idx == 6'd5 && sif.gate) begin
                wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h71;
                rewrote = 1'b1;
            end
            if (done) done_c++;
            prev_v = sif.note_valid;
            if (offers > 0 && !busy) fin = 1'b1;
        end
        n_checks++; if (!fin) begin n_fail++; $display("FAIL fill_timeout: got busy=%b expected idle within 3000 cycles", busy); end
        n_checks++; if (offers != 64) begin n_fail++; $display("FAIL fill_offers: got %0d expected 64", offers); end
        n_checks++; if (bad_note != 0) begin n_fail++; $display("FAIL fill_note: got %0d wrong notes expected 0", bad_note); end
        n_checks++; if (!rewrote) begin n_fail++; $display("FAIL fill_rewrite: got no entry 5 play expected one"); end
        n_checks++; if (bad5 != 0) begin n_fail++; $display("FAIL fill_entry5_note: got %0d changed cycles expected 0", bad5); end
        n_checks++; if (g5 != EXP_GATE) begin n_fail++; $display("FAIL fill_entry5_ticks: got %0d expected %0d", g5, EXP_GATE); end
        n_checks++; if (done_c != 1) begin n_fail++; $display("FAIL fill_done: got %0d expected 1", done_c); end
        n_checks++; if (idx !== 6'd0) begin n_fail++; $display("FAIL fill_idx_end: got %0d expected 0", idx); end
    endtask

    initial begin
        sif.note_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_loop();
        test_stop();
        test_fill_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
